ram_emu_responder: RTL and testbench
====================================

# ram_emu_responder

FPGA-side model of the serial RAM emulator: it answers read/write requests arriving on the 2-lane serial link that `julia_top` drives on `tx_pins`/`rx_pins`. It is used to close the link on-chip for simulation and bring-up without the RP2040 attached. It holds an internal word memory that the host can preload, decodes serial requests, performs writes, and returns read data as serial responses after a fixed turnaround.

## Interface
- `ADDR_BITS`, 16: request address width. Must be even.
- `DATA_BITS`, 16: data word width. Must be even.
- `MEM_ADDR_BITS`, 10: implemented memory depth is 2^MEM_ADDR_BITS words.
- `RESP_DELAY`, 2: turnaround cycles between the last address beat and the response start symbol. Must be ≥1.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_pins`  in  2  request lanes, driven by the initiator's `tx_pins`. Already registered upstream.
- `tx_pins`  out  2  response lanes, driven to the initiator's `rx_pins`. Registered.
- `load_en`  in  1  host preload strobe.
- `load_addr`  in  MEM_ADDR_BITS  preload address.
- `load_data`  in  DATA_BITS  preload word.
- `busy`  out  1  high in every state except IDLE.
- `dropped`  out  1  one-cycle pulse when a start symbol arrives while the block is not in IDLE.

## Operation
- Beat counts: A = ADDR_BITS/2, D = DATA_BITS/2.
- Each beat carries 2 bits. Lane 1 is the MSB of the beat. Words are sent LSB-first.
- Start symbol: `rx_pins[0]`=1 sampled while in IDLE. `rx_pins[1]` on that cycle selects the request type: 0 = read, 1 = write.
- States:
  - IDLE → RX_ADDR on a start symbol.
  - RX_ADDR: shifts in A beats. Then goes to RX_DATA for a write, or WAIT for a read.
  - RX_DATA: shifts in D beats. Memory is written on the edge that captures the final beat. Then → IDLE.
  - WAIT: RESP_DELAY cycles. Then → TX_START.
  - TX_START: `tx_pins`=01 for one cycle. Then → TX_DATA.
  - TX_DATA: D beats from the read word, LSB-first. Then → IDLE.
- Memory index is `addr[MEM_ADDR_BITS-1:0]`. Upper address bits are ignored, so addresses wrap.
- Read data is captured from memory on the edge that accepts the final address beat. The memory uses read-before-write semantics.
- `load_en` writes memory in any state. If a load and a protocol write hit the same cycle and address, the load wins.
- `rx_pins` is ignored outside IDLE and RX states. A start symbol (`rx_pins[0]`=1) seen in WAIT, TX_START or TX_DATA pulses `dropped` and is otherwise discarded.
- `tx_pins`=00 in all states other than TX_START and TX_DATA.

## Timing
- Reset values (async): state IDLE, `tx_pins`=00, `busy`=0, `dropped`=0, beat counters 0. Memory contents are not reset.
- Start symbol sampled at cycle S. Address beats occupy cycles S+1..S+A.
- Read: `tx_pins`=01 in cycle S+A+RESP_DELAY+1. Data beats occupy the next D cycles. `tx_pins`=00 and IDLE from cycle S+A+RESP_DELAY+D+2.
- Write: data beats occupy S+A+1..S+A+D. The block is IDLE at S+A+D+1 and can accept a new start on that cycle.
- Back-to-back requests are legal with zero idle cycles between them.
- `busy` is registered with the state: high from S+1 through the last beat.
- Reset asserted mid-operation: output goes to `tx_pins`=00 immediately, the partial request is discarded, and no memory write occurs.

## Test plan
- Reset: assert `reset` with `rx_pins`=11 → `tx_pins`=00, `busy`=0 throughout. After release, the first start symbol is accepted.
- Read preloaded word: load 0x0012←0xA5C3. Send start 01, then address beats 10,00,01,00,00,00,00,00 → `tx_pins`=01 at S+11, then 11,00,00,11,01,01,10,10, then 00.
- Write then read: write 0xBEEF to 0x0345, then immediately read 0x0345 → response word 0xBEEF. Second start accepted at S+17.
- Address wrap: write 0x1234 to 0xFC05, read 0x0005 → 0x1234.
- Drop: during the WAIT of a read, drive `rx_pins`=01 for one cycle → `dropped` pulses once, the response is unchanged, and the block ends in IDLE.
- Reset mid-write: assert reset after 4 data beats of a write to 0x0001 (preloaded 0x5555) → reading 0x0001 returns 0x5555.

Source files
------------

// File: rtl/ram_emu_responder.sv
// Serial RAM emulator responder: decodes 2-lane read/write requests against an
// internal word memory and returns read data as a serial response after a fixed turnaround.
module ram_emu_responder #(
  parameter int ADDR_BITS     = 16,
  parameter int DATA_BITS     = 16,
  parameter int MEM_ADDR_BITS = 10,
  parameter int RESP_DELAY    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               rx_pins,
  output logic [1:0]               tx_pins,
  input  logic                     load_en,
  input  logic [MEM_ADDR_BITS-1:0] load_addr,
  input  logic [DATA_BITS-1:0]     load_data,
  output logic                     busy,
  output logic                     dropped
);

  localparam int A    = ADDR_BITS / 2;
  localparam int D    = DATA_BITS / 2;
  localparam int CMAX = (A > D) ? ((A > RESP_DELAY) ? A : RESP_DELAY)
                                : ((D > RESP_DELAY) ? D : RESP_DELAY);
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, RX_ADDR, RX_DATA, WAIT, TX_START, TX_DATA} state_e;

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   is_wr_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [DATA_BITS-3:0]   data_q;
  logic [DATA_BITS-1:0]   rd_word_q;
  logic [DATA_BITS-1:0]   tx_sh_q;
  logic [1:0]             tx_q;
  logic                   busy_q;
  logic                   dropped_q;

  logic [DATA_BITS-1:0]   mem_q [2**MEM_ADDR_BITS];

  // Incoming beats land in the MSB slot so an LSB-first word ends up aligned.
  logic [ADDR_BITS-1:0]   addr_d;
  logic [DATA_BITS-1:0]   data_d;
  logic                   last_addr, wr_en;

  assign addr_d    = {rx_pins, addr_q[ADDR_BITS-1:2]};
  assign data_d    = {rx_pins, data_q};
  assign last_addr = (state_q == RX_ADDR) && (cnt_q == CW'(A - 1));
  assign wr_en     = (state_q == RX_DATA) && (cnt_q == CW'(D - 1));

  // Read-before-write memory; the host load is issued last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (last_addr) rd_word_q <= mem_q[addr_d[MEM_ADDR_BITS-1:0]];
    if (wr_en)     mem_q[addr_q[MEM_ADDR_BITS-1:0]] <= data_d;
    if (load_en)   mem_q[load_addr] <= load_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      tx_sh_q   <= '0;
      tx_q      <= 2'b00;
      busy_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      dropped_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_pins[0]) begin
            state_q <= RX_ADDR;
            is_wr_q <= rx_pins[1];
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RX_ADDR: begin
          addr_q <= addr_d;
          if (cnt_q == CW'(A - 1)) begin
            cnt_q   <= '0;
            state_q <= is_wr_q ? RX_DATA : WAIT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          data_q <= data_d[DATA_BITS-1:2];
          if (cnt_q == CW'(D - 1)) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT: begin
          dropped_q <= rx_pins[0];
          if (cnt_q == CW'(RESP_DELAY - 1)) begin
            cnt_q   <= '0;
            state_q <= TX_START;
            tx_q    <= 2'b01;
            tx_sh_q <= rd_word_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        TX_START: begin
          dropped_q <= rx_pins[0];
          tx_q      <= tx_sh_q[1:0];
          tx_sh_q   <= {2'b00, tx_sh_q[DATA_BITS-1:2]};
          state_q   <= TX_DATA;
        end
        TX_DATA: begin
          dropped_q <= rx_pins[0];
          if (cnt_q == CW'(D - 1)) begin
            cnt_q   <= '0;
            tx_q    <= 2'b00;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            tx_q    <= tx_sh_q[1:0];
            tx_sh_q <= {2'b00, tx_sh_q[DATA_BITS-1:2]};
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 2'b00;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_pins = tx_q;
  assign busy    = busy_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_ram_emu_responder.sv
// Directed bench for ram_emu_responder: stimulus pushes expected read responses
// into a scoreboard, a negedge monitor decodes tx_pins and compares.
module tb_ram_emu_responder;
  localparam int A  = 8;
  localparam int D  = 8;
  localparam int RD = 2;

  logic       clk, reset;
  logic [1:0] rx_pins, tx_pins;
  logic       load_en, busy, dropped;
  logic [9:0] load_addr;
  logic [15:0] load_data;

  ram_emu_responder dut (
    .clk(clk), .reset(reset), .rx_pins(rx_pins), .tx_pins(tx_pins),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0, drop_cnt = 0;

  typedef struct { logic [15:0] word; int cyc; } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor
  int          mon_st = 0, mon_beat = 0, mon_cyc = 0;
  logic [15:0] mon_word;
  always @(negedge clk) begin
    if (!reset && dropped === 1'b1) drop_cnt++;
    if (reset) begin
      mon_st = 0;
    end else begin
      case (mon_st)
        0: if (tx_pins !== 2'b00) begin
             chk("resp_start_sym", {30'd0, tx_pins}, 32'd1);
             mon_cyc = cyc; mon_beat = 0; mon_word = '0; mon_st = 1;
           end
        1: begin
             mon_word[2*mon_beat +: 2] = tx_pins;
             mon_beat++;
             if (mon_beat == D) mon_st = 2;
           end
        default: begin
             exp_t e;
             chk("resp_end_idle", {30'd0, tx_pins}, 32'd0);
             if (sb_q.size() == 0) begin
               chk("resp_unexpected", {16'd0, mon_word}, 32'hFFFF_FFFF);
             end else begin
               e = sb_q.pop_front();
               chk("resp_word", {16'd0, mon_word}, {16'd0, e.word});
               chk("resp_start_cycle", mon_cyc, e.cyc);
             end
             mon_st = 0;
           end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [9:0] a, input logic [15:0] d);
    load_en = 1; load_addr = a; load_data = d;
    tick();
    load_en = 0;
  endtask

  task automatic send_read(input logic [15:0] addr, input logic [15:0] exp_w, input bit drop);
    int s;
    exp_t e;
    s = cyc;
    rx_pins = 2'b01;
    tick();
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < A; i++) begin
      rx_pins = addr[2*i +: 2];
      tick();
    end
    rx_pins = 2'b00;
    e.word = exp_w; e.cyc = s + A + RD + 1;
    sb_q.push_back(e);
    if (drop) begin
      rx_pins = 2'b01;
      tick();
      rx_pins = 2'b00;
    end
    while (cyc < s + A + RD + D + 2) tick();
    chk("busy_after_read", busy, 0);
  endtask

  task automatic send_write(input logic [15:0] addr, input logic [15:0] data,
                            input int abort_at, input bit collide, input logic [15:0] ldw);
    rx_pins = 2'b11;
    tick();
    chk("busy_after_wstart", busy, 1);
    for (int i = 0; i < A; i++) begin
      rx_pins = addr[2*i +: 2];
      tick();
    end
    for (int i = 0; i < D; i++) begin
      if (i == abort_at) begin
        reset = 1;
        #1;
        chk("midrst_tx", {30'd0, tx_pins}, 0);
        chk("midrst_busy", busy, 0);
        tick(); tick();
        reset = 0; rx_pins = 2'b00;
        tick();
        return;
      end
      rx_pins = data[2*i +: 2];
      if (collide && i == D - 1) begin
        load_en = 1; load_addr = addr[9:0]; load_data = ldw;
      end
      tick();
      load_en = 0;
    end
    rx_pins = 2'b00;
    chk("busy_after_write", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int d0;
    clk = 0; reset = 1; rx_pins = 2'b11;
    load_en = 0; load_addr = '0; load_data = '0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_tx", {30'd0, tx_pins}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dropped", dropped, 0);
    end
    @(posedge clk); #1;
    reset = 0; rx_pins = 2'b00;

    load(10'h012, 16'hA5C3);
    load(10'h001, 16'h5555);
    tick();

    send_read(16'h0012, 16'hA5C3, 0);

    // Back-to-back write then read; the read start lands at S+17 of the write
    send_write(16'h0345, 16'hBEEF, -1, 0, '0);
    send_read(16'h0345, 16'hBEEF, 0);

    send_write(16'hFC05, 16'h1234, -1, 0, '0);
    send_read(16'h0005, 16'h1234, 0);

    d0 = drop_cnt;
    send_read(16'h0012, 16'hA5C3, 1);
    chk("drop_pulses", drop_cnt - d0, 1);

    send_write(16'h0020, 16'h1111, -1, 1, 16'h2222);
    send_read(16'h0020, 16'h2222, 0);

    send_write(16'h0001, 16'hABCD, 4, 0, '0);
    send_read(16'h0001, 16'h5555, 0);

    for (int i = 0; i < 200 && (sb_q.size() != 0 || mon_st != 0); i++) tick();
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("drop_total", drop_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
